// File: rtl/rgb_mixer_multi_pkg.sv
// Shared types for the multi-lane encoder-to-PWM mixer.
package rgb_mixer_multi_pkg;

    // Direction of a single decoded encoder step
    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_DOWN = 2'd2
    } step_e;

    // x1 quadrature decode: only a rising edge of A counts, B picks the direction
    function automatic step_e decode_step(input logic a, input logic a_prev, input logic b);
        step_e s;
        s = STEP_NONE;
        if (a && !a_prev) begin
            s = b ? STEP_DOWN : STEP_UP;
        end
        return s;
    endfunction

endpackage

// File: rtl/rgb_mixer_lane.sv
// One mixer lane: A/B debouncers, x1 decoder and the level register with
// direct load and saturate/wrap arithmetic.
module rgb_mixer_lane
    import rgb_mixer_multi_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEB_LEN  = 8,
    parameter int SATURATE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] level
);

    localparam logic [WIDTH-1:0] MAX_LEVEL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO      = '0;
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [DEB_LEN-1:0] sh_a_q, sh_a_d;
    logic [DEB_LEN-1:0] sh_b_q, sh_b_d;
    logic               deb_a_q, deb_a_d;
    logic               deb_b_q, deb_b_d;
    logic               a_prev_q, a_prev_d;
    logic [WIDTH-1:0]   level_q, level_d;
    step_e              step;

    // Debounce: shift raw samples in; output only moves on a full run of equal samples
    always_comb begin
        sh_a_d  = {sh_a_q[DEB_LEN-2:0], enc_a};
        sh_b_d  = {sh_b_q[DEB_LEN-2:0], enc_b};
        deb_a_d = deb_a_q;
        deb_b_d = deb_b_q;
        if (&sh_a_q) begin
            deb_a_d = 1'b1;
        end else if (~|sh_a_q) begin
            deb_a_d = 1'b0;
        end
        if (&sh_b_q) begin
            deb_b_d = 1'b1;
        end else if (~|sh_b_q) begin
            deb_b_d = 1'b0;
        end
    end

    // Decode and level update; a direct load overrides any step in the same cycle
    always_comb begin
        a_prev_d = deb_a_q;
        step     = decode_step(deb_a_q, a_prev_q, deb_b_q);
        level_d  = level_q;
        if (load_en) begin
            level_d = load_value;
        end else begin
            case (step)
                STEP_UP: begin
                    if (!((SATURATE != 0) && (level_q == MAX_LEVEL))) begin
                        level_d = level_q + ONE;
                    end
                end
                STEP_DOWN: begin
                    if (!((SATURATE != 0) && (level_q == ZERO))) begin
                        level_d = level_q - ONE;
                    end
                end
                default: level_d = level_q;
            endcase
        end
    end

    // Lane state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            deb_a_q  <= 1'b0;
            deb_b_q  <= 1'b0;
            a_prev_q <= 1'b0;
            level_q  <= '0;
        end else begin
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            deb_a_q  <= deb_a_d;
            deb_b_q  <= deb_b_d;
            a_prev_q <= a_prev_d;
            level_q  <= level_d;
        end
    end

    assign level = level_q;

endmodule

// File: rtl/rgb_mixer_multi.sv
// Multi-channel encoder-to-PWM mixer: CHANNELS independent lanes sharing one
// free-running PWM counter, with period-aligned duty updates.
module rgb_mixer_multi
    import rgb_mixer_multi_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 8,
    parameter int DEB_LEN  = 8,
    parameter int SATURATE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       enc_a,
    input  logic [CHANNELS-1:0]       enc_b,
    input  logic                      load_valid,
    input  logic [3:0]                load_ch,
    input  logic [WIDTH-1:0]          load_value,
    output logic [CHANNELS*WIDTH-1:0] level,
    output logic [CHANNELS-1:0]       pwm_out
);

    localparam logic [WIDTH-1:0] MAX_LEVEL = {WIDTH{1'b1}};
    localparam int               CH_IDX_W  = 4;

    logic [CHANNELS-1:0]            lane_load_en;
    logic [CHANNELS-1:0][WIDTH-1:0] lane_level;
    logic [CHANNELS-1:0][WIDTH-1:0] active_q, active_d;
    logic [WIDTH-1:0]               cnt_q, cnt_d;
    logic [CHANNELS-1:0]            pwm_q, pwm_d;

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_lane
            // An out-of-range load_ch matches no lane, so the write is dropped
            assign lane_load_en[gi] = load_valid && (load_ch == CH_IDX_W'(gi));

            rgb_mixer_lane #(
                .WIDTH    (WIDTH),
                .DEB_LEN  (DEB_LEN),
                .SATURATE (SATURATE)
            ) u_lane (
                .clk        (clk),
                .reset      (reset),
                .enc_a      (enc_a[gi]),
                .enc_b      (enc_b[gi]),
                .load_en    (lane_load_en[gi]),
                .load_value (load_value),
                .level      (lane_level[gi])
            );
        end
    endgenerate

    // Shared counter, active levels latched only at the wrap, and PWM compare
    always_comb begin
        cnt_d    = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
        active_d = active_q;
        pwm_d    = '0;
        if (cnt_q == MAX_LEVEL) begin
            active_d = lane_level;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            pwm_d[i] = (cnt_q < active_q[i]);
        end
    end

    // PWM state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q    <= '0;
            active_q <= '0;
            pwm_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
        end
    end

    assign level   = lane_level;
    assign pwm_out = pwm_q;

endmodule

// File: tb/tb_rgb_mixer_multi.sv
// Scoreboard bench for rgb_mixer_multi: a saturating and a wrapping instance
// share stimulus; expected levels/duties are queued at stimulus time.
module tb_rgb_mixer_multi;

    localparam int DEB_LEN = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  enc_a, enc_b;
    logic        load_valid;
    logic [3:0]  load_ch;
    logic [7:0]  load_value;
    logic [23:0] level_s, level_w;
    logic [2:0]  pwm_s, pwm_w;

    int n_checks = 0;
    int n_err    = 0;
    int tb_cnt   = 0;
    int ms[3];
    int mw[3];

    string       sb_tag[$];
    logic [31:0] sb_exp[$];

    rgb_mixer_multi #(.CHANNELS(3), .WIDTH(8), .DEB_LEN(DEB_LEN), .SATURATE(1)) dut_sat (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .load_valid(load_valid), .load_ch(load_ch), .load_value(load_value),
        .level(level_s), .pwm_out(pwm_s)
    );

    rgb_mixer_multi #(.CHANNELS(3), .WIDTH(8), .DEB_LEN(DEB_LEN), .SATURATE(0)) dut_wrp (
        .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
        .load_valid(load_valid), .load_ch(load_ch), .load_value(load_value),
        .level(level_w), .pwm_out(pwm_w)
    );

    always #5 clk = ~clk;

    // Reference phase of the shared PWM counter
    always @(posedge clk) begin
        if (!reset) tb_cnt <= 0;
        else        tb_cnt <= (tb_cnt + 1) % 256;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        sb_tag.push_back(tag);
        sb_exp.push_back(val);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        if (sb_exp.size() == 0) begin
            chk("sb_underflow", 32'(sb_exp.size()), 32'd1);
        end else begin
            chk(sb_tag.pop_front(), obs, sb_exp.pop_front());
        end
    endtask

    function automatic logic [31:0] vec_s();
        return {8'h00, 8'(ms[2]), 8'(ms[1]), 8'(ms[0])};
    endfunction

    function automatic logic [31:0] vec_w();
        return {8'h00, 8'(mw[2]), 8'(mw[1]), 8'(mw[0])};
    endfunction

    task automatic push_levels(input string tag);
        sb_push({tag, "_sat"}, vec_s());
        sb_push({tag, "_wrp"}, vec_w());
    endtask

    task automatic check_levels();
        sb_pop({8'h00, level_s});
        sb_pop({8'h00, level_w});
    endtask

    // One encoder detent on the channels in mask; optional load on the step edge
    task automatic step(input logic [2:0] mask, input logic [2:0] down, input bit ld,
                        input int lch, input logic [7:0] lval, input string tag);
        enc_b = down;
        repeat (DEB_LEN + 2) @(negedge clk);
        enc_a = mask;
        repeat (DEB_LEN + 1) @(negedge clk);
        push_levels({tag, "_early"});
        check_levels();
        if (ld) begin
            load_valid = 1'b1;
            load_ch    = 4'(lch);
            load_value = lval;
        end
        @(negedge clk);
        load_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (ld && lch == c) begin
                ms[c] = lval;
                mw[c] = lval;
            end else if (mask[c]) begin
                if (down[c]) begin
                    ms[c] = (ms[c] == 0) ? 0 : ms[c] - 1;
                    mw[c] = (mw[c] + 255) % 256;
                end else begin
                    ms[c] = (ms[c] == 255) ? 255 : ms[c] + 1;
                    mw[c] = (mw[c] + 1) % 256;
                end
            end
        end
        push_levels(tag);
        check_levels();
        enc_a = 3'b000;
        repeat (DEB_LEN + 3) @(negedge clk);
    endtask

    task automatic load_drive(input int lch, input logic [7:0] lval);
        load_valid = 1'b1;
        load_ch    = 4'(lch);
        load_value = lval;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    task automatic load(input int lch, input logic [7:0] lval, input string tag);
        load_drive(lch, lval);
        if (lch < 3) begin
            ms[lch] = lval;
            mw[lch] = lval;
        end
        push_levels(tag);
        check_levels();
    endtask

    // Count high cycles per channel over one full PWM period starting at a wrap
    task automatic measure(input string tag, input int e0, input int e1, input int e2);
        int hs[3];
        int hw[3];
        int guard;
        sb_push({tag, "_s0"}, 32'(e0));
        sb_push({tag, "_s1"}, 32'(e1));
        sb_push({tag, "_s2"}, 32'(e2));
        sb_push({tag, "_w0"}, 32'(e0));
        sb_push({tag, "_w1"}, 32'(e1));
        sb_push({tag, "_w2"}, 32'(e2));
        for (int c = 0; c < 3; c++) begin
            hs[c] = 0;
            hw[c] = 0;
        end
        guard = 0;
        while (tb_cnt != 0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_align"}, 32'(tb_cnt), 32'd0);
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            for (int c = 0; c < 3; c++) begin
                hs[c] += int'(pwm_s[c]);
                hw[c] += int'(pwm_w[c]);
            end
        end
        for (int c = 0; c < 3; c++) sb_pop(32'(hs[c]));
        for (int c = 0; c < 3; c++) sb_pop(32'(hw[c]));
    endtask

    initial begin
        logic [31:0] idle_bad;
        int          guard;
        reset      = 1'b0;
        enc_a      = '0;
        enc_b      = '0;
        load_valid = 1'b0;
        load_ch    = '0;
        load_value = '0;
        for (int c = 0; c < 3; c++) begin
            ms[c] = 0;
            mw[c] = 0;
        end

        // Reset and idle
        repeat (5) @(negedge clk);
        chk("rst_level_sat", {8'h00, level_s}, 32'd0);
        chk("rst_level_wrp", {8'h00, level_w}, 32'd0);
        chk("rst_pwm_sat", {29'd0, pwm_s}, 32'd0);
        chk("rst_pwm_wrp", {29'd0, pwm_w}, 32'd0);
        reset = 1'b1;
        idle_bad = '0;
        repeat (600) begin
            @(negedge clk);
            idle_bad |= {8'h00, level_s | level_w} | {29'd0, pwm_s | pwm_w};
        end
        chk("idle_quiet", idle_bad, 32'd0);

        // Debounce: short glitch ignored, clean rise steps with exact latency
        enc_a = 3'b001;
        repeat (DEB_LEN - 1) @(negedge clk);
        enc_a = 3'b000;
        repeat (20) @(negedge clk);
        push_levels("glitch");
        check_levels();
        step(3'b001, 3'b000, 1'b0, 0, 8'h00, "deb_up");

        // Direction and saturation on channel 1
        repeat (3) step(3'b010, 3'b000, 1'b0, 0, 8'h00, "ch1_up");
        repeat (5) step(3'b010, 3'b010, 1'b0, 0, 8'h00, "ch1_dn");
        load(1, 8'd254, "ld254");
        repeat (3) step(3'b010, 3'b000, 1'b0, 0, 8'h00, "ch1_top");
        load(1, 8'd255, "ld255");
        step(3'b010, 3'b000, 1'b0, 0, 8'h00, "ch1_wrap");

        // Load collides with a step on channel 2 while channel 0 steps normally
        step(3'b101, 3'b000, 1'b1, 2, 8'h40, "collide");
        load(5, 8'h99, "bad_ch");

        // PWM duty and period alignment
        guard = 0;
        while (tb_cnt != 10 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        load(1, 8'd0, "pwm_ld1");
        load(2, 8'd255, "pwm_ld2");
        load(0, 8'd64, "pwm_ld0");
        measure("duty_a", 64, 0, 255);
        fork
            measure("duty_b", 64, 0, 255);
            begin
                repeat (100) @(negedge clk);
                load_drive(0, 8'd192);
            end
        join
        ms[0] = 192;
        mw[0] = 192;
        push_levels("ld192");
        check_levels();
        measure("duty_c", 192, 0, 255);

        // Reset mid-operation
        repeat (100) @(negedge clk);
        chk("pre_rst_pwm2", {31'd0, pwm_s[2]}, 32'd1);
        chk("pre_rst_lvl", {8'h00, level_s}, vec_s());
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_level_sat", {8'h00, level_s}, 32'd0);
        chk("midrst_level_wrp", {8'h00, level_w}, 32'd0);
        chk("midrst_pwm_sat", {29'd0, pwm_s}, 32'd0);
        chk("midrst_pwm_wrp", {29'd0, pwm_w}, 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        chk("sb_drain", 32'(sb_exp.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/rgb_mixer_multi.md
Name: rgb_mixer_multi

Overview:
- Parametrised successor of the three-channel encoder-to-PWM mixer.
- Provides CHANNELS independent lanes. Each lane is: quadrature inputs -> debounce -> x1 quadrature decoder -> saturating or wrapping level register -> PWM output.
- Adds behaviour the previous mixer lacks:
  - a direct level-load port;
  - level readback;
  - a selectable saturate/wrap mode;
  - period-aligned (glitch-free) PWM level updates.
- All channels share one PWM counter.

Parameters:
- CHANNELS, 3, number of encoder/PWM lanes (1..16).
- WIDTH, 8, level and PWM counter width in bits (2..16).
- DEB_LEN, 8, number of consecutive equal samples required by each debouncer (2..32).
- SATURATE, 1, 1 = level clamps at 0 and 2^WIDTH-1; 0 = level wraps modulo 2^WIDTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- enc_a  in  CHANNELS  encoder A phase, bit i = channel i.
- enc_b  in  CHANNELS  encoder B phase, bit i = channel i.
- load_valid  in  1  one-cycle direct level write strobe.
- load_ch  in  4  target channel of the write.
- load_value  in  WIDTH  level to write.
- level  out  CHANNELS*WIDTH  current level registers; channel i occupies bits [i*WIDTH +: WIDTH].
- pwm_out  out  CHANNELS  registered PWM outputs.

Behaviour:
- Reset: all state is updated only on the rising edge of clk, with reset sampled low. Reset forces:
  - debounce shift registers and debounced outputs to 0;
  - decoder history to 0;
  - level to 0;
  - active (period-latched) levels to 0;
  - PWM counter to 0;
  - pwm_out to 0.
- Reset asserted mid-operation wins over every other event in the same cycle.
- Debounce, per input bit:
  - a DEB_LEN-bit shift register samples the raw input every cycle;
  - when all DEB_LEN bits are 1 the debounced output becomes 1; when all are 0 it becomes 0; otherwise it holds.
  - Latency: a clean input change is visible on the debounced signal on the edge after the DEB_LEN-th equal sample (DEB_LEN+1 edges after the change).
  - Pulses shorter than DEB_LEN cycles are ignored.
- Decoder:
  - registers the previous debounced A;
  - a step occurs on a debounced-A rising edge (a & !a_prev);
  - debounced B = 0 -> +1; debounced B = 1 -> -1;
  - falling A edges and B-only changes produce no step;
  - the level updates on the same edge the step is detected, one cycle after debounced A rises.
- Arithmetic:
  - SATURATE=1: +1 at 2^WIDTH-1 holds; -1 at 0 holds.
  - SATURATE=0: modulo 2^WIDTH (255+1 -> 0, 0-1 -> 255 for WIDTH=8).
- Direct load:
  - load_valid with load_ch < CHANNELS writes load_value to level[load_ch] on that edge;
  - if an encoder step hits the same channel in the same cycle, the load wins and the step is discarded;
  - other channels step normally;
  - load_ch >= CHANNELS: the write is ignored, no state change.
- PWM:
  - a shared WIDTH-bit counter free-runs 0 -> 2^WIDTH-1 -> 0;
  - each channel latches level into its active level on the edge where the counter wraps to 0;
  - pwm_out[i] <= (counter < active[i]), registered, one cycle behind the counter;
  - active = 0 -> output always low; active = 2^WIDTH-1 -> high for 2^WIDTH-1 of every 2^WIDTH cycles;
  - the duty never changes inside a period.
- Each channel is fully independent; simultaneous steps on all channels are all applied.

Decomposition:
- Shared package: none required. Local parameter MAX_LEVEL = 2^WIDTH-1 and a channel-index width constant live in the top module.
- Sub-module rgb_mixer_lane: two debouncers, the decoder, and the level register with load/saturate logic. The lane takes WIDTH, DEB_LEN and SATURATE as parameters.
- The top module instantiates CHANNELS lanes via generate, and holds the shared counter and the per-channel active-level/compare logic.

Test Plan:
- Reset and idle:
  - Stimulus: hold reset low 5 cycles, then release with all inputs 0 for 600 cycles.
  - Required: level = 0 and pwm_out = 0 throughout.
- Debounce filter (DEB_LEN=8):
  - Stimulus: 7-cycle glitch on enc_a[0].
  - Required: no step; level[0] stays 0.
  - Stimulus: enc_a[0] held high 8+ cycles with enc_b[0] = 0.
  - Required: level[0] = 1 exactly DEB_LEN+2 edges after the rise.
- Direction and saturation (SATURATE=1, WIDTH=8):
  - Stimulus: 3 up-steps then 5 down-steps on channel 1.
  - Required: level[1] reads 3, then 0, and never underflows.
  - Stimulus: load 254, then 3 up-steps.
  - Required: 255 held.
  - Also run with SATURATE=0: load 255, then 1 up-step gives 0.
- Load collision:
  - Stimulus: load_valid with load_ch=2, load_value=0x40 on the same edge as an up-step on channel 2, plus an up-step on channel 0.
  - Required: level[2] = 0x40, level[0] increments.
  - Stimulus: load_ch=5.
  - Required: no level changes.
- PWM duty and alignment:
  - Stimulus: load 64 into channel 0.
  - Required: pwm_out[0] is high for exactly 64 of 256 cycles per period, starting at the first counter wrap after the load.
  - Stimulus: load 192 mid-period.
  - Required: the current period keeps 64; the next period has 192.
  - Level 0: never high. Level 255: high for 255 of 256 cycles.
- Reset mid-operation:
  - Stimulus: assert reset while levels are nonzero and the PWM is high.
  - Required: on the next edge all levels, counter and pwm_out are 0.
